// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, the instruction memory and the decode side.
// Performance-counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] im_address;
    logic [31:0] im_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        misalign;
    logic        range_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] perf_redirects;
`endif

    // master: the fetch stage itself
    modport master (
        input  stall, flush, redirect, redirect_pc, im_inst,
        output im_address, ifid_pc, ifid_pc4, ifid_inst, ifid_valid,
`ifdef FETCH_PERF_CNT_EN
        output perf_fetched, perf_stalls, perf_redirects,
`endif
        output misalign, range_err
    );

    // slave: hazard unit, instruction memory and decode stage
    modport slave (
        output stall, flush, redirect, redirect_pc, im_inst,
        input  im_address, ifid_pc, ifid_pc4, ifid_inst, ifid_valid,
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetched, perf_stalls, perf_redirects,
`endif
        input  misalign, range_err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, sticky redirect-error flags.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);
    localparam logic [31:0] MEM_SIZE  = 32'(IMEM_BYTES);

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] target;
    logic        bubble;
    logic        load_ifid;

    // All PC arithmetic lives in the instruction-memory window
    assign pc_seq    = (pc + 32'd4) & ADDR_MASK;
    assign target    = bus.redirect_pc & ADDR_MASK & ~32'd3;
    assign bubble    = bus.flush | bus.redirect;
    assign load_ifid = ~bubble & ~bus.stall;

    assign bus.im_address = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.redirect) begin
            pc <= target;
        end else if (!bus.stall) begin
            pc <= pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            bus.ifid_pc    <= 32'd0;
            bus.ifid_pc4   <= 32'd0;
            bus.ifid_inst  <= NOP_INST;
            bus.ifid_valid <= 1'b0;
        end else if (load_ifid) begin
            bus.ifid_pc    <= pc;
            bus.ifid_pc4   <= pc_seq;
            bus.ifid_inst  <= bus.im_inst;
            bus.ifid_valid <= 1'b1;
        end
    end

    // Flags look at the raw target; the redirect itself still uses the masked one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.misalign  <= 1'b0;
            bus.range_err <= 1'b0;
        end else if (bus.redirect) begin
            bus.misalign  <= bus.misalign  | (bus.redirect_pc[1:0] != 2'b00);
            bus.range_err <= bus.range_err | (bus.redirect_pc >= MEM_SIZE);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.perf_fetched   <= 32'd0;
            bus.perf_stalls    <= 32'd0;
            bus.perf_redirects <= 32'd0;
        end else begin
            if (load_ifid) begin
                bus.perf_fetched <= bus.perf_fetched + 32'd1;
            end
            if (bus.stall && !bubble) begin
                bus.perf_stalls <= bus.perf_stalls + 32'd1;
            end
            if (bus.redirect) begin
                bus.perf_redirects <= bus.perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by randomized traffic,
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int          IMEM  = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RSTPC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic        mis;
        logic        rng;
        logic [31:0] pf;
        logic [31:0] ps;
        logic [31:0] pr;
    } exp_t;

    logic clk;
    logic rst_n;
    fetch_stage_if bus ();

    logic [31:0] mem [IMEM/4];
    exp_t        expq [$];

    int testsRun;
    int testsFailed;

    // behavioural model state
    longint unsigned mPc, mIfPc, mIfPc4, mInst;
    bit              mValid, mMis, mRng;
    longint unsigned mPf, mPs, mPr;

    fetch_stage #(.RESET_PC(RSTPC), .IMEM_BYTES(IMEM), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    assign bus.im_inst = mem[bus.im_address[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and push the model's view of the state after the next edge
    task automatic applyStimulus(input bit rst, input bit stall, input bit flush,
                                 input bit redirect, input logic [31:0] rpc);
        exp_t e;
        longint unsigned nextSeq;
        @(negedge clk);
        rst_n           = ~rst;
        bus.stall       = stall;
        bus.flush       = flush;
        bus.redirect    = redirect;
        bus.redirect_pc = rpc;
        if (rst) begin
            mPc = RSTPC; mIfPc = 0; mIfPc4 = 0; mInst = NOP; mValid = 0;
            mMis = 0; mRng = 0; mPf = 0; mPs = 0; mPr = 0;
        end else begin
            nextSeq = (mPc + 4) % IMEM;
            if (redirect) begin
                if (rpc % 4 != 0) mMis = 1;
                if (longint'(rpc) >= IMEM) mRng = 1;
                mPr = (mPr + 1) % (64'd1 << 32);
            end
            if (flush || redirect) begin
                mIfPc = 0; mIfPc4 = 0; mInst = NOP; mValid = 0;
            end else if (!stall) begin
                mIfPc = mPc; mIfPc4 = nextSeq; mInst = mem[mPc / 4]; mValid = 1;
                mPf = (mPf + 1) % (64'd1 << 32);
            end else begin
                mPs = (mPs + 1) % (64'd1 << 32);
            end
            if (redirect) mPc = ((longint'(rpc) % IMEM) / 4) * 4;
            else if (!stall) mPc = nextSeq;
        end
        e.addr = 32'(mPc); e.pc = 32'(mIfPc); e.pc4 = 32'(mIfPc4); e.inst = 32'(mInst);
        e.valid = mValid; e.mis = mMis; e.rng = mRng;
        e.pf = 32'(mPf); e.ps = 32'(mPs); e.pr = 32'(mPr);
        expq.push_back(e);
    endtask

    // Monitor: every edge that has a pending expectation is compared away from the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("im_address", bus.im_address, e.addr);
                checkOutput("ifid_pc", bus.ifid_pc, e.pc);
                checkOutput("ifid_pc4", bus.ifid_pc4, e.pc4);
                checkOutput("ifid_inst", bus.ifid_inst, e.inst);
                checkOutput("ifid_valid", 32'(bus.ifid_valid), 32'(e.valid));
                checkOutput("misalign", 32'(bus.misalign), 32'(e.mis));
                checkOutput("range_err", 32'(bus.range_err), 32'(e.rng));
`ifdef FETCH_PERF_CNT_EN
                checkOutput("perf_fetched", bus.perf_fetched, e.pf);
                checkOutput("perf_stalls", bus.perf_stalls, e.ps);
                checkOutput("perf_redirects", bus.perf_redirects, e.pr);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.redirect = 0; bus.redirect_pc = 0;
        for (int k = 0; k < IMEM/4; k++) mem[k] = 32'(k);

        // reset, then sequential fetch
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0);
        // stall for three cycles at pc 8
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0);
        // redirect to 0x40 at pc 0x10
        applyStimulus(0, 0, 0, 1, 32'h40);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        // bad target together with stall
        applyStimulus(0, 1, 0, 1, 32'h142);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
        // walk across the wrap point, then a lone flush
        for (int i = 0; i < 60; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0);
        // reset in the middle of a stall
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        for (int k = 0; k < IMEM/4; k++) mem[k] = $urandom;

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, IMEM - 1));
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0,
                          rpc);
        end

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
